// File: rtl/masked_max_pkg.sv
// Shared helpers for the masked-maximum finder: clog2, padded leaf count and
// the frame accumulator state encoding.
package masked_max_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } acc_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Leaves of the comparison tree, rounded up to a power of two.
  function automatic int pad_leaves(input int n);
    return 1 << clog2(n);
  endfunction

endpackage

// File: rtl/masked_max_node.sv
// One registered two-input masked comparator. Index ports exist only when
// MASKED_MAX_NREG_ARGMAX_EN is defined.
module masked_max_node #(
  parameter int WIDTH = 16
`ifdef MASKED_MAX_NREG_ARGMAX_EN
  ,
  parameter int IDX_W = 3
`endif
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] a_val,
  input  logic             a_mask,
  input  logic [WIDTH-1:0] b_val,
  input  logic             b_mask,
`ifdef MASKED_MAX_NREG_ARGMAX_EN
  input  logic [IDX_W-1:0] a_idx,
  input  logic [IDX_W-1:0] b_idx,
  output logic [IDX_W-1:0] y_idx,
`endif
  output logic [WIDTH-1:0] y_val,
  output logic             y_mask
);

  logic sel_b;

  // a is the lower channel index, so equal values keep a.
  assign sel_b = b_mask && (!a_mask || (b_val > a_val));

  always_ff @(posedge clk) begin
    y_mask <= a_mask | b_mask;
    if (!(a_mask | b_mask)) y_val <= '0;
    else                    y_val <= sel_b ? b_val : a_val;
  end

`ifdef MASKED_MAX_NREG_ARGMAX_EN
  always_ff @(posedge clk) begin
    y_idx <= sel_b ? b_idx : a_idx;
  end
`endif

endmodule

// File: rtl/masked_max_nreg.sv
// Pipelined masked maximum over CHANNELS inputs with per-frame accumulation.
// Define MASKED_MAX_NREG_ARGMAX_EN to build winner index and beat tracking.
module masked_max_nreg
  import masked_max_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8,
  parameter int BEAT_W   = 16,
  localparam int LEVELS  = clog2(CHANNELS),
  localparam int IDX_W   = (LEVELS < 1) ? 1 : LEVELS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_mask,
  input  logic                      in_first,
  input  logic                      in_last,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_max,
  output logic                      out_any,
  output logic [IDX_W-1:0]          out_idx,
  output logic [BEAT_W-1:0]         out_beat
);

  localparam int NLEAF = pad_leaves(CHANNELS);
  localparam int NNODE = 2 * NLEAF - 1;

  logic [CHANNELS*WIDTH-1:0] data_p0;
  logic [CHANNELS-1:0]       mask_p0;
  logic [LEVELS:0]           vld_p;
  logic [LEVELS:0]           first_p;
  logic [LEVELS:0]           last_p;

  // Stage p0: input register; flags are qualified by in_valid here.
  always_ff @(posedge clk) begin
    data_p0 <= in_data;
    mask_p0 <= in_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p   <= '0;
      first_p <= '0;
      last_p  <= '0;
    end else begin
      vld_p   <= {vld_p[LEVELS-1:0], in_valid};
      first_p <= {first_p[LEVELS-1:0], in_valid & in_first};
      last_p  <= {last_p[LEVELS-1:0], in_valid & in_last};
    end
  end

  // Stages p1..pLEVELS: heap-ordered tree, node k fed by 2k+1 (lower) and 2k+2.
  logic [WIDTH-1:0] t_val  [NNODE];
  logic             t_mask [NNODE];
`ifdef MASKED_MAX_NREG_ARGMAX_EN
  logic [IDX_W-1:0] t_idx  [NNODE];
`endif

  for (genvar i = 0; i < NLEAF; i++) begin : g_leaf
    if (i < CHANNELS) begin : g_real
      assign t_val[NLEAF-1+i]  = data_p0[i*WIDTH +: WIDTH];
      assign t_mask[NLEAF-1+i] = mask_p0[i];
    end else begin : g_pad
      assign t_val[NLEAF-1+i]  = '0;
      assign t_mask[NLEAF-1+i] = 1'b0;
    end
`ifdef MASKED_MAX_NREG_ARGMAX_EN
    assign t_idx[NLEAF-1+i] = IDX_W'(i);
`endif
  end

  for (genvar k = 0; k < NLEAF - 1; k++) begin : g_node
    masked_max_node #(
      .WIDTH(WIDTH)
`ifdef MASKED_MAX_NREG_ARGMAX_EN
      ,
      .IDX_W(IDX_W)
`endif
    ) u_node (
      .clk   (clk),
      .a_val (t_val[2*k+1]),
      .a_mask(t_mask[2*k+1]),
      .b_val (t_val[2*k+2]),
      .b_mask(t_mask[2*k+2]),
`ifdef MASKED_MAX_NREG_ARGMAX_EN
      .a_idx (t_idx[2*k+1]),
      .b_idx (t_idx[2*k+2]),
      .y_idx (t_idx[k]),
`endif
      .y_val (t_val[k]),
      .y_mask(t_mask[k])
    );
  end

  // Final stage: frame accumulator and registered result.
  acc_state_e       state;
  logic [WIDTH-1:0] acc_max, nxt_max;
  logic             acc_any, nxt_any;
  logic             r_vld, r_first, r_last;
  logic             open_beat, cont_beat, take, load, emit;

  assign r_vld     = vld_p[LEVELS];
  assign r_first   = first_p[LEVELS];
  assign r_last    = last_p[LEVELS];
  assign open_beat = r_vld && r_first;
  assign cont_beat = r_vld && !r_first && (state == ST_ACC);
  assign take      = t_mask[0] && (!acc_any || (t_val[0] > acc_max));
  assign load      = open_beat || (cont_beat && take);
  assign emit      = (open_beat || cont_beat) && r_last;

  always_comb begin
    nxt_max = acc_max;
    nxt_any = acc_any;
    if (load) begin
      nxt_max = t_val[0];
      nxt_any = t_mask[0];
    end
  end

  always_ff @(posedge clk) begin
    if (open_beat || cont_beat) begin
      acc_max <= nxt_max;
      acc_any <= nxt_any;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_max   <= '0;
      out_any   <= 1'b0;
    end else begin
      out_valid <= emit;
      if (emit) begin
        out_max <= nxt_max;
        out_any <= nxt_any;
      end
      if (open_beat)                state <= r_last ? ST_IDLE : ST_ACC;
      else if (cont_beat && r_last) state <= ST_IDLE;
    end
  end

`ifdef MASKED_MAX_NREG_ARGMAX_EN
  function automatic logic [BEAT_W-1:0] sat_inc(input logic [BEAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [IDX_W-1:0]  acc_idx, nxt_idx;
  logic [BEAT_W-1:0] acc_beat, nxt_beat, beat_cnt, cur_beat;

  assign cur_beat = r_first ? '0 : sat_inc(beat_cnt);

  always_comb begin
    nxt_idx  = acc_idx;
    nxt_beat = acc_beat;
    if (load) begin
      nxt_idx  = t_idx[0];
      nxt_beat = cur_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (open_beat || cont_beat) begin
      beat_cnt <= cur_beat;
      acc_idx  <= nxt_idx;
      acc_beat <= nxt_beat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_idx  <= '0;
      out_beat <= '0;
    end else if (emit) begin
      out_idx  <= nxt_any ? nxt_idx : '0;
      out_beat <= nxt_any ? nxt_beat : '0;
    end
  end
`else
  assign out_idx  = '0;
  assign out_beat = '0;
`endif

endmodule

// File: doc/masked_max_nreg.md
# masked_max_nreg

Pipelined masked-maximum finder over CHANNELS parallel inputs, with optional per-frame accumulation across successive beats. It reduces the masked channels through a registered binary comparison tree, then keeps a running maximum over a frame delimited by first/last flags. It sits in statistics paths, such as per-tile peak search and histogram maxima, where the old two-input, single-stage comparator is no longer enough.

## Interface
- WIDTH, 16: unsigned data width per channel.
- CHANNELS, 8: parallel inputs; legal range 2..32.
- BEAT_W, 16: width of the beat counter.
- IDX_W: localparam, clog2(CHANNELS); minimum 1.
- LEVELS: localparam, clog2(CHANNELS); number of tree stages.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_data  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- in_mask  in  CHANNELS  1 = channel valid.
- in_first  in  1  beat opens a frame; qualified by in_valid.
- in_last  in  1  beat closes a frame; qualified by in_valid.
- out_valid  out  1  one-cycle pulse carrying the frame result.
- out_max  out  WIDTH  frame maximum over masked-in samples; 0 if none.
- out_any  out  1  at least one masked-in sample in the frame.
- out_idx  out  IDX_W  channel of the winner.
- out_beat  out  BEAT_W  beat number of the winner within its frame; the first beat is 0.

## Operation
- Tree node, on two masked inputs a (lower index) and b:
  - b is selected iff mask_b && (!mask_a || b > a).
  - Node outputs are registered: value, index, and mask_a||mask_b.
  - Value is 0 when both inputs are masked.
- Ties go to the lower channel index.
- When CHANNELS is not a power of two, the tree is padded with permanently masked leaves.
- in_valid, in_first and in_last travel alongside the data through every tree stage. Bubbles (in_valid=0) pass through and never touch the accumulator.
- Accumulator states:
  - IDLE → ACC on a valid beat with first=1 and last=0.
  - ACC → IDLE on a valid beat with last=1.
  - IDLE → IDLE on a beat with first=1 and last=1 (single-beat frame).
- Accumulator datapath:
  - Frame open: the accumulator loads the beat's tree result and the beat counter loads 0.
  - Later beats replace the accumulator only if the beat is valid && (!acc_any || beat_max > acc_max). Ties go to the earliest beat.
- Beat counter increments per valid beat and saturates at all-ones. A winner after saturation reports the saturated value.
- Boundary cases:
  - Valid beat without first while IDLE: ignored entirely.
  - first while ACC: the open frame is discarded without output and a new frame starts.
  - last on a frame with no masked-in samples: out_valid=1, out_any=0, out_max=0, out_idx=0, out_beat=0.
- Reset mid-frame clears every pipeline stage and returns the FSM to IDLE. No partial result is ever emitted.

## Timing
- Reset values: every output 0, FSM IDLE, all pipeline valid bits 0.
- Input-to-result latency is LEVELS+1 cycles: a last beat sampled at edge k gives out_valid high after edge k+LEVELS+1.
- Fully pipelined: one beat per cycle, no backpressure.
- Result outputs hold between pulses. Only out_valid is a pulse.
- Back-to-back frames are legal: last on beat n and first on beat n+1.

## Configuration
- MASKED_MAX_NREG_ARGMAX_EN defined: index and beat tracking are built. out_idx and out_beat are valid as above.
- Not defined: no index registers or beat counter are synthesized. out_idx and out_beat are tied to 0; the port list is unchanged.
- out_max, out_any and out_valid are identical in both builds.

## Structure
- Package masked_max_pkg holds:
  - the clog2 constant function;
  - the FSM state encoding (IDLE, ACC);
  - the padded-leaf count function, 2**clog2(CHANNELS).
- Sub-module masked_max_node: one registered two-input masked comparator carrying value, mask and index, with width parameters.
- The top level instantiates masked_max_node in a generate tree and adds the accumulator FSM.

## Test plan
- Single-beat frame, CHANNELS=8, mask=8'hFF, ch3=0x1234 as the only maximum, others 0x0100 → out_valid after 4 cycles, max=0x1234, idx=3, beat=0, any=1.
- Tie: ch2=ch5=0x0F00, all masked in → idx=2. Then mask ch2 off → idx=5.
- Three-beat frame with beat maxima 0x0010, 0x0500, 0x0500 → max=0x0500, beat=1. A bubble between beats changes nothing.
- Frame with all masks 0 → out_valid=1, any=0, max=0. Also a valid beat sent while IDLE → no output.
- first arriving mid-frame, then last two beats later → one output covering only the new frame. rst_n asserted mid-frame → no output and all outputs 0.
- CHANNELS=5, with and without MASKED_MAX_NREG_ARGMAX_EN, random masks/data over 10k frames against a reference model → matches. out_idx and out_beat are 0 when the macro is undefined.
